// File: rtl/cooling_euler_stepper_pkg.sv
// Shared widths, FSM encoding and the 32-bit saturation helper for the
// solveCooling Euler-stepper datapath.
package cooling_pkg;
  localparam int DATA_W = 32;
  localparam int FRAC_W = 16;
  localparam int PROD_W = 48;
  localparam int STEP_W = 16;

  localparam logic [DATA_W-1:0] KDT_MAX = 32'h00007FFF;

  typedef enum logic [2:0] {IDLE, DIFF, MUL, ACC, EMIT, DONE} state_t;

  // Clamp a wide signed value into the signed Q16.16 range.
  function automatic logic [DATA_W-1:0] sat32(input logic signed [PROD_W-1:0] v);
    if (v > $signed(48'h0000_7FFF_FFFF)) begin
      return 32'h7FFF_FFFF;
    end else if (v < $signed(48'hFFFF_8000_0000)) begin
      return 32'h8000_0000;
    end else begin
      return v[DATA_W-1:0];
    end
  endfunction
endpackage

// File: rtl/cooling_euler_stepper_mul.sv
// Signed 32x32 multiplier keeping the low 48 product bits; output register
// only loads when ce is high, so dout is valid the cycle after ce.
module solveCooling_mul_32s_32s_48_2_1
  import cooling_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic [PROD_W-1:0] dout
);
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] prod;
  logic [PROD_W-1:0]        dout_q;
  logic [PROD_W-1:0]        dout_d;

  // Callers bound |product| < 2^47, so the 48-bit modular product is exact.
  always_comb begin
    a_ext  = {{(PROD_W-DATA_W){din0[DATA_W-1]}}, din0};
    b_ext  = {{(PROD_W-DATA_W){din1[DATA_W-1]}}, din1};
    prod   = a_ext * b_ext;
    dout_d = ce ? prod : dout_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
endmodule

// File: rtl/cooling_euler_stepper.sv
// Explicit-Euler sequencer: T[n+1] = T[n] + k_dt*(t_env - T[n]) in Q16.16,
// one sample per step streamed over a valid/ready port.
module cooling_euler_stepper
  import cooling_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] t_init,
  input  logic [DATA_W-1:0] t_env,
  input  logic [DATA_W-1:0] k_dt,
  input  logic [STEP_W-1:0] n_steps,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_temp,
  output logic [STEP_W-1:0] out_idx,
  output logic              done
);
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   t_q, t_d;
  logic [DATA_W-1:0]   env_q, env_d;
  logic [DATA_W-1:0]   kdt_q, kdt_d;
  logic [DATA_W-1:0]   diff_q, diff_d;
  logic [STEP_W-1:0]   nsteps_q, nsteps_d;
  logic [STEP_W-1:0]   idx_q, idx_d;
  logic                mul_ce;
  logic [PROD_W-1:0]   mul_dout;
  logic signed [PROD_W-1:0] diff_wide;
  logic signed [PROD_W-1:0] delta;
  logic signed [PROD_W-1:0] sum_wide;

  solveCooling_mul_32s_32s_48_2_1 u_mul (
    .clk   (clk),
    .reset (reset),
    .ce    (mul_ce),
    .din0  (diff_q),
    .din1  (kdt_q),
    .dout  (mul_dout)
  );

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    env_d     = env_q;
    kdt_d     = kdt_q;
    diff_d    = diff_q;
    nsteps_d  = nsteps_q;
    idx_d     = idx_q;
    mul_ce    = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    diff_wide = $signed({{(PROD_W-DATA_W){env_q[DATA_W-1]}}, env_q})
              - $signed({{(PROD_W-DATA_W){t_q[DATA_W-1]}}, t_q});
    delta     = $signed(mul_dout) >>> FRAC_W;
    sum_wide  = $signed({{(PROD_W-DATA_W){t_q[DATA_W-1]}}, t_q}) + delta;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          t_d      = t_init;
          env_d    = t_env;
          // Non-negative k_dt below 2^15 keeps the product inside 48 bits.
          if (k_dt[DATA_W-1]) begin
            kdt_d = '0;
          end else if (k_dt > KDT_MAX) begin
            kdt_d = KDT_MAX;
          end else begin
            kdt_d = k_dt;
          end
          nsteps_d = n_steps;
          idx_d    = '0;
          state_d  = (n_steps == '0) ? DONE : DIFF;
        end
      end
      DIFF: begin
        diff_d  = sat32(diff_wide);
        state_d = MUL;
      end
      MUL: begin
        mul_ce  = 1'b1;
        state_d = ACC;
      end
      ACC: begin
        t_d     = sat32(sum_wide);
        state_d = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx_q == nsteps_q - 1'b1) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = DIFF;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      t_q      <= '0;
      env_q    <= '0;
      kdt_q    <= '0;
      diff_q   <= '0;
      nsteps_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      env_q    <= env_d;
      kdt_q    <= kdt_d;
      diff_q   <= diff_d;
      nsteps_q <= nsteps_d;
      idx_q    <= idx_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign out_temp = t_q;
  assign out_idx  = idx_q;
endmodule
